// File: rtl/buzzer_pkg.sv
// buzzer_pkg: tone table, register bit positions and reset values shared by the buzzer block
package buzzer_pkg;
  localparam logic [7:0][4:0] HALF_PERIODS_DEF = {5'd28, 5'd24, 5'd20, 5'd16, 5'd14, 5'd12, 5'd10, 5'd8};
  localparam int TONE_EN = 3;
  localparam int BZ_OFF = 3;
  localparam logic [3:0] FREQ_SEL_RST = 4'h0;
  localparam logic [3:0] OUT_CTRL_RST = 4'h8;
endpackage

// File: rtl/buzzer_divider.sv
// buzzer_divider: programmable divide-by-2N toggler, idle holds counter and output low
module buzzer_divider (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [4:0] n,
  output logic       buzzer
);
  logic [4:0] r_cnt;
  logic       r_bz;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_bz  <= 1'b0;
    end else if (!run) begin
      r_cnt <= '0;
      r_bz  <= 1'b0;
    end else if (r_cnt >= n - 5'd1) begin
      // >= rather than == so a shorter period selected mid-count toggles at once
      r_cnt <= '0;
      r_bz  <= ~r_bz;
    end else begin
      r_cnt <= r_cnt + 5'd1;
    end
  end
  assign buzzer = r_bz;
endmodule

// File: rtl/buzzer_tone_generator.sv
// buzzer_tone_generator: frequency-select and output-control registers gating a square-wave divider
module buzzer_tone_generator
  import buzzer_pkg::*;
#(
  parameter logic [7:0][4:0] HALF_PERIODS = HALF_PERIODS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reg_we,
  input  logic       reg_sel,
  input  logic [3:0] reg_wdata,
  output logic [3:0] buzzer_frequency_selection,
  output logic [3:0] buzzer_output_control,
  output logic       buzzer
);
  logic [3:0] r_freq_sel;
  logic [3:0] r_out_ctrl;
  logic       w_run;
  logic [4:0] w_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_freq_sel <= FREQ_SEL_RST;
      r_out_ctrl <= OUT_CTRL_RST;
    end else if (reg_we) begin
      if (reg_sel) r_out_ctrl <= reg_wdata;
      else r_freq_sel <= reg_wdata;
    end
  end
  assign w_run = r_freq_sel[TONE_EN] & ~r_out_ctrl[BZ_OFF];
  assign w_n = HALF_PERIODS[r_freq_sel[2:0]];
  assign buzzer_frequency_selection = r_freq_sel;
  assign buzzer_output_control = r_out_ctrl;
  buzzer_divider u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (w_run),
    .n      (w_n),
    .buzzer (buzzer)
  );
endmodule

// File: tb/tb_buzzer_tone_generator.sv
// tb_buzzer_tone_generator: directed stimulus with a cycle-stamped scoreboard and negedge monitor
module tb_buzzer_tone_generator;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reg_we = 1'b0;
  logic       reg_sel = 1'b0;
  logic [3:0] reg_wdata = 4'h0;
  logic [3:0] buzzer_frequency_selection;
  logic [3:0] buzzer_output_control;
  logic       buzzer;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] exp;
    string      name;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ns_tab[8] = '{8, 10, 12, 14, 16, 20, 24, 28};

  buzzer_tone_generator dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .reg_we                    (reg_we),
    .reg_sel                   (reg_sel),
    .reg_wdata                 (reg_wdata),
    .buzzer_frequency_selection(buzzer_frequency_selection),
    .buzzer_output_control     (buzzer_output_control),
    .buzzer                    (buzzer)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void push(int c, int s, logic [3:0] e, string nm);
    ent_t x;
    x.cyc = c; x.sig = s; x.exp = e; x.name = nm;
    q.push_back(x);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent_t e;
      logic [3:0] act;
      e = q.pop_front();
      act = (e.sig == 0) ? {3'b000, buzzer} : (e.sig == 1) ? buzzer_frequency_selection : buzzer_output_control;
      if (e.cyc != cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s missed slot cyc=%0d want_cyc=%0d", e.name, cyc, e.cyc);
      end else chk(e.name, act, e.exp);
    end
  end

  // Called just after a negedge; the write lands on the following posedge, whose cycle is returned.
  task automatic wr(input logic sel, input logic [3:0] d, output int w);
    reg_we = 1'b1; reg_sel = sel; reg_wdata = d;
    w = cyc + 1;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int w, c1, n;
    repeat (3) @(negedge clk);
    chk("rst_buzzer", {3'b000, buzzer}, 4'h0);
    chk("rst_freq", buzzer_frequency_selection, 4'h0);
    chk("rst_ctrl", buzzer_output_control, 4'h8);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      n = ns_tab[k];
      wr(1'b0, {1'b1, 3'(k)}, w);
      push(w, 1, {1'b1, 3'(k)}, $sformatf("k%0d_freq_rb", k));
      wr(1'b1, 4'h7, c1);
      push(c1, 2, 4'h7, $sformatf("k%0d_ctrl_rb", k));
      for (int e = 1; e <= 4; e++) begin
        push(c1 + e * n - 1, 0, (e % 2 == 1) ? 4'h0 : 4'h1, $sformatf("k%0d_pre%0d", k, e));
        push(c1 + e * n, 0, (e % 2 == 1) ? 4'h1 : 4'h0, $sformatf("k%0d_post%0d", k, e));
      end
      wait_until(c1 + 4 * n);
      wr(1'b1, 4'h8, w);
      for (int i = 1; i <= 3; i++) push(w + i, 0, 4'h0, $sformatf("k%0d_off", k));
      wait_until(w + 4);
    end
    wr(1'b0, 4'h5, w);
    wr(1'b1, 4'h7, c1);
    for (int i = 1; i <= 200; i++) push(c1 + i, 0, 4'h0, "tone_dis_idle");
    wait_until(c1 + 201);
    wr(1'b1, 4'h8, w);
    wr(1'b0, 4'hF, w);
    wr(1'b1, 4'h7, c1);
    push(c1 + 20, 0, 4'h0, "sw_pre");
    push(c1 + 20, 1, 4'h8, "sw_freq_rb");
    wait_until(c1 + 19);
    wr(1'b0, 4'h8, w);
    push(c1 + 21, 0, 4'h1, "sw_toggle");
    push(c1 + 28, 0, 4'h1, "sw_hold");
    push(c1 + 29, 0, 4'h0, "sw_fall");
    push(c1 + 36, 0, 4'h0, "sw_low");
    push(c1 + 37, 0, 4'h1, "sw_rise");
    wait_until(c1 + 38);
    wr(1'b1, 4'h8, w);
    wr(1'b1, 4'h7, c1);
    push(c1 + 8, 0, 4'h1, "off_high");
    wait_until(c1 + 9);
    wr(1'b1, 4'h8, w);
    push(w, 0, 4'h1, "off_same_edge");
    push(w, 2, 4'h8, "off_ctrl_rb");
    for (int i = 1; i <= 20; i++) push(w + i, 0, 4'h0, "off_low");
    wait_until(w + 22);
    wr(1'b0, 4'hB, w);
    wr(1'b1, 4'h7, c1);
    wait_until(c1 + 16);
    chk("mid_high", {3'b000, buzzer}, 4'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_buzzer", {3'b000, buzzer}, 4'h0);
    chk("async_rst_freq", buzzer_frequency_selection, 4'h0);
    chk("async_rst_ctrl", buzzer_output_control, 4'h8);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain left=%0d", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
